// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions and small types used by the arbitrated ALU slice.
// Every user of the ALU opcodes imports this package.
package alu_pkg;

   localparam int ALU_OP_W = 4;

   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam alu_op_t ALU_AND = 4'b0000;
   localparam alu_op_t ALU_OR  = 4'b0001;
   localparam alu_op_t ALU_ADD = 4'b0010;
   localparam alu_op_t ALU_SUB = 4'b0110;
   localparam alu_op_t ALU_EQ  = 4'b1000;

   typedef enum logic {
      RSP_EMPTY = 1'b0,
      RSP_FULL  = 1'b1
   } rsp_state_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU shared by the EX-stage requesters.
// Opcodes it does not decode produce a zero result.
module alu
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  alu_op_t               operation,
   input  logic [DATA_WIDTH-1:0] src_a,
   input  logic [DATA_WIDTH-1:0] src_b,
   output logic [DATA_WIDTH-1:0] alu_result
);

   always_comb begin
      // NOTE: default assignment first so no path through the case can infer a latch.
      alu_result = '0;
      unique case (operation)
         ALU_AND: alu_result = src_a & src_b;
         ALU_OR:  alu_result = src_a | src_b;
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         ALU_EQ:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (src_a == src_b)};
         default: alu_result = '0;
      endcase
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first valid request scanning from ptr upward, modulo NUM_REQ.
// Purely combinational; at most one grant bit is set.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   logic            found;
   int              idx;
   logic [ID_W-1:0] sel;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      sel       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr never exceeds NUM_REQ-1, so a single conditional subtract is the modulo
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = ID_W'(idx);
         if (!found && req[sel]) begin
            found      = 1'b1;
            grant[sel] = 1'b1;
            grant_idx  = sel;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration and a
// single registered, back-pressurable response slot tagged with the requester index.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int NUM_REQ       = 2,
   parameter int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          rsp_valid,
   output logic [ID_W-1:0]               rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_result,
   input  logic                          rsp_ready
);

   logic [OPCODE_LENGTH-1:0] op_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0]    a_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0]    b_arr  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr[g] = req_op[g*OPCODE_LENGTH +: OPCODE_LENGTH];
      assign a_arr[g]  = req_a[g*DATA_WIDTH +: DATA_WIDTH];
      assign b_arr[g]  = req_b[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rsp_state_t               state, state_nxt;
   logic [ID_W-1:0]          rr_ptr, rr_ptr_nxt;
   logic [NUM_REQ-1:0]       grant;
   logic [ID_W-1:0]          grant_idx;
   logic                     space;
   logic                     accept;
   logic [OPCODE_LENGTH-1:0] sel_op;
   logic [DATA_WIDTH-1:0]    sel_a, sel_b;
   logic [DATA_WIDTH-1:0]    alu_result;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .req       (req_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign rsp_valid = (state == RSP_FULL);
   assign space     = !rsp_valid || rsp_ready;
   // Gated by rst_n so nothing is offered as accepted while reset is held.
   assign req_ready = rst_n ? (grant & {NUM_REQ{space}}) : '0;
   assign accept    = |req_ready;

   assign sel_op = op_arr[grant_idx];
   assign sel_a  = a_arr[grant_idx];
   assign sel_b  = b_arr[grant_idx];

   alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .operation  (alu_op_t'(sel_op)),
      .src_a      (sel_a),
      .src_b      (sel_b),
      .alu_result (alu_result)
   );

   assign rr_ptr_nxt = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

   always_comb begin
      state_nxt = state;
      unique case (state)
         RSP_EMPTY: if (accept) state_nxt = RSP_FULL;
         RSP_FULL:  if (rsp_ready && !accept) state_nxt = RSP_EMPTY;
         default:   state_nxt = RSP_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RSP_EMPTY;
      end else begin
         // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
         state <= state_nxt;
      end
   end

   // NOTE: the response payload is reset too, so a discarded response never shows stale data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         rsp_id     <= '0;
         rsp_result <= '0;
      end else if (accept) begin
         rr_ptr     <= rr_ptr_nxt;
         rsp_id     <= grant_idx;
         rsp_result <= alu_result;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (three requesters): a reference model predicts
// grants and queues expected responses, which are compared when the DUT presents them.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int DW = 32;
   localparam int OW = 4;
   localparam int NR = 3;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*OW-1:0]  req_op = '0;
   logic [NR*DW-1:0]  req_a = '0;
   logic [NR*DW-1:0]  req_b = '0;
   logic [NR-1:0]     req_ready;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_id;
   logic [DW-1:0]     rsp_result;
   logic              rsp_ready = 1'b1;

   alu_arbiter #(
      .DATA_WIDTH    (DW),
      .OPCODE_LENGTH (OW),
      .NUM_REQ       (NR),
      .ID_W          (IW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_ready  (rsp_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] id;
      logic [DW-1:0] res;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          m_ptr    = 0;
   logic        m_valid  = 1'b0;
   logic [NR-1:0] last_ready = '0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] ref_alu(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      case (op)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b1000: return (a == b) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   task automatic set_req(input int i, input logic v, input logic [OW-1:0] op,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_valid[i]         = v;
      req_op[i*OW +: OW]   = op;
      req_a[i*DW +: DW]    = a;
      req_b[i*DW +: DW]    = b;
   endtask

   // One clock: predict and compare at the falling edge, then advance past the rising edge.
   task automatic step();
      int            gi;
      logic          found;
      logic          space;
      logic [NR-1:0] exp_ready;
      exp_t          e;
      @(negedge clk);
      space = !m_valid || rsp_ready;
      found = 1'b0;
      gi    = 0;
      for (int k = 0; k < NR; k++) begin
         int idx;
         idx = (m_ptr + k) % NR;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gi    = idx;
         end
      end
      exp_ready = (found && space) ? (NR'(1) << gi) : '0;
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, m_valid);
      if (m_valid) begin
         if (sb.size() == 0) begin
            check("sb_size", sb.size(), 1);
         end else begin
            check("rsp_id", rsp_id, sb[0].id);
            check("rsp_result", rsp_result, sb[0].res);
            if (rsp_ready) void'(sb.pop_front());
         end
      end
      last_ready = req_ready;
      if (found && space) begin
         e.id  = IW'(gi);
         e.res = ref_alu(req_op[gi*OW +: OW], req_a[gi*DW +: DW], req_b[gi*DW +: DW]);
         sb.push_back(e);
         m_ptr   = (gi + 1) % NR;
         m_valid = 1'b1;
      end else if (rsp_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          ids[5];
      logic [DW-1:0] res[5];
      logic [OW-1:0] ops[6];
      ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_EQ, 4'b1111};

      // Reset state, with requests already pending.
      req_valid = '1;
      #3;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_rsp_result", rsp_result, 0);
      check("reset_req_ready", req_ready, 0);
      req_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single op: req0 ADD 5+7.
      set_req(0, 1'b1, ALU_ADD, 32'd5, 32'd7);
      step();
      set_req(0, 1'b0, ALU_AND, 32'd0, 32'd0);
      check("single_id", rsp_id, 0);
      check("single_result", rsp_result, 12);
      step();

      // Contention: pointer now sits at 1, so grants alternate 1,0,1,0 with no idle cycles.
      set_req(0, 1'b1, ALU_SUB, 32'd10, 32'd3);
      set_req(1, 1'b1, ALU_AND, 32'hF0, 32'h3C);
      ids = '{1, 0, 1, 0, 0};
      res = '{32'h30, 32'd7, 32'h30, 32'd7, 32'd0};
      for (int i = 0; i < 4; i++) begin
         step();
         check("cont_valid", rsp_valid, 1);
         check("cont_id", rsp_id, ids[i]);
         check("cont_result", rsp_result, res[i]);
      end

      // Back-pressure: response (id 0, 7) held for three cycles, then drain+accept together.
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_hold_result", rsp_result, 7);
         check("bp_hold_id", rsp_id, 0);
      end
      rsp_ready = 1'b1;
      step();
      check("bp_release_id", rsp_id, 1);
      check("bp_release_result", rsp_result, 32'h30);

      // Wrap and fairness with all three valid: 2 -> 0 -> 1 -> 2 -> 0.
      set_req(2, 1'b1, ALU_OR, 32'h0F, 32'hF0);
      ids = '{2, 0, 1, 2, 0};
      res = '{32'hFF, 32'd7, 32'h30, 32'hFF, 32'd7};
      for (int i = 0; i < 5; i++) begin
         step();
         check("wrap_id", rsp_id, ids[i]);
         check("wrap_result", rsp_result, res[i]);
      end

      // Only req1 valid: it wins every cycle.
      set_req(0, 1'b0, ALU_AND, 32'd0, 32'd0);
      set_req(2, 1'b0, ALU_AND, 32'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("solo_id", rsp_id, 1);
      end

      // Undecoded opcode still returns a response, with zero result.
      set_req(1, 1'b0, ALU_AND, 32'd0, 32'd0);
      set_req(2, 1'b1, 4'b1111, 32'd3, 32'd4);
      step();
      check("badop_id", rsp_id, 2);
      check("badop_result", rsp_result, 0);
      check("badop_valid", rsp_valid, 1);

      // Reset mid-operation: outputs clear immediately, without a clock edge.
      set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
      set_req(1, 1'b1, ALU_ADD, 32'd2, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_rsp_id", rsp_id, 0);
      check("midrst_rsp_result", rsp_result, 0);
      check("midrst_req_ready", req_ready, 0);
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
      set_req(0, 1'b0, ALU_AND, 32'd0, 32'd0);
      set_req(1, 1'b0, ALU_AND, 32'd0, 32'd0);
      set_req(2, 1'b0, ALU_AND, 32'd0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // First grant after reset goes to requester 0, then req1's EQ 9==9.
      set_req(0, 1'b1, ALU_AND, 32'hFF, 32'h0F);
      set_req(1, 1'b1, ALU_EQ, 32'd9, 32'd9);
      step();
      check("post_rst_first_id", rsp_id, 0);
      set_req(0, 1'b0, ALU_AND, 32'd0, 32'd0);
      step();
      check("post_rst_eq_id", rsp_id, 1);
      check("post_rst_eq_result", rsp_result, 1);

      // Random traffic honouring the hold-until-ready contract.
      for (int c = 0; c < 60; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] || last_ready[i]) begin
               set_req(i, 1'($urandom_range(0, 1)), ops[$urandom_range(0, 5)],
                       32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // Drain.
      set_req(0, 1'b0, ALU_AND, 32'd0, 32'd0);
      set_req(1, 1'b0, ALU_AND, 32'd0, 32'd0);
      set_req(2, 1'b0, ALU_AND, 32'd0, 32'd0);
      rsp_ready = 1'b1;
      step();
      step();
      check("drain_sb_empty", sb.size(), 0);
      check("drain_rsp_valid", rsp_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
